// File: rtl/branch_outcome_queue.sv
// Branch outcome queue: decouples execute-stage branch resolution from the
// global predictor's update port, and keeps saturating branch/mispredict stats.
module branch_outcome_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_pc,
    input  logic                     enq_taken,
    input  logic                     enq_predicted,
    output logic                     enq_ready,
    input  logic                     clear,
    input  logic                     pred_stall,
    output logic                     pred_write_en,
    output logic [31:0]              pred_pc,
    output logic                     pred_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              branch_count,
    output logic [31:0]              mispredict_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic          taken_mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [31:0]   branch_count_q, branch_count_d;
    logic [31:0]   mispredict_count_q, mispredict_count_d;
    logic          mispredict_q, mispredict_d;

    logic          accept;
    logic          pop;
    logic          is_mispredict;

    assign enq_ready     = (occ_q != FULL_COUNT) & ~clear;
    assign pred_write_en = (occ_q != '0) & ~pred_stall & ~clear;
    assign accept        = enq_valid & enq_ready;
    assign pop           = pred_write_en;
    assign is_mispredict = enq_taken ^ enq_predicted;

    assign pred_pc          = pc_mem_q[head_q];
    assign pred_taken       = taken_mem_q[head_q];
    assign mispredict       = mispredict_q;
    assign occupancy        = occ_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    // Next-state for pointers, occupancy and statistics; clear wins over push and pop.
    always_comb begin
        head_d             = head_q;
        tail_d             = tail_q;
        occ_d              = occ_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        mispredict_d       = accept & is_mispredict;

        if (clear) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (accept) begin
                tail_d = tail_q + PW'(1);
            end
            case ({accept, pop})
                2'b10:   occ_d = occ_q + CW'(1);
                2'b01:   occ_d = occ_q - CW'(1);
                default: occ_d = occ_q;
            endcase
        end

        if (accept && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (accept && is_mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // Control state register; reset discards every queued entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q             <= '0;
            tail_q             <= '0;
            occ_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            mispredict_q       <= 1'b0;
        end else begin
            head_q             <= head_d;
            tail_q             <= tail_d;
            occ_q              <= occ_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            mispredict_q       <= mispredict_d;
        end
    end

    // Entry storage is left unreset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem_q[tail_q]    <= enq_pc;
            taken_mem_q[tail_q] <= enq_taken;
        end
    end

endmodule
